// File: rtl/mac_acc_tc.sv
// Multiply-accumulate tail: sums a run of signed 32-bit products into an ACC_W-bit accumulator.
// Optional build macro MAC_ACC_SAT_EN clamps on signed overflow instead of wrapping.
module mac_acc_tc #(
    parameter int ACC_W = 40
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [7:0]       len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      product,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic             busy,
    output logic             ovf
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam logic [ACC_W-1:0] POS_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] NEG_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    state_e           state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;

    logic [ACC_W-1:0] prod_ext;
    logic [ACC_W-1:0] sum;
    logic             add_ovf;
    logic [ACC_W-1:0] add_res;

    // Overflow only when both operands share a sign and the result sign flips.
    always_comb begin
        prod_ext = ACC_W'($signed(product));
        sum      = acc_q + prod_ext;
        add_ovf  = (acc_q[ACC_W-1] == product[31]) && (sum[ACC_W-1] != acc_q[ACC_W-1]);
`ifdef MAC_ACC_SAT_EN
        add_res  = add_ovf ? (product[31] ? NEG_MIN : POS_MAX) : sum;
`else
        add_res  = sum;
`endif
    end

    always_comb begin
        // NOTE: every _d gets a default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    cnt_d   = len;
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = (len != 8'd0) ? S_ACC : S_DONE;
                end
            end
            S_ACC: begin
                if (in_valid && in_ready_q) begin
                    acc_d = add_res;
                    ovf_d = ovf_q | add_ovf;
                    cnt_d = cnt_q - 8'd1;
                    if (cnt_q == 8'd1) state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        in_ready_d  = (state_d == S_ACC);
        out_valid_d = (state_d == S_DONE);
        busy_d      = (state_d != S_IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign acc_out   = acc_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_mac_acc_tc.sv
// Bench for mac_acc_tc: a 40-bit and a 33-bit instance share stimulus; a queue scoreboard
// checks each result handshake, and table vectors plus hand sequences cover the corner cases.
module tb_mac_acc_tc;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  len;
    logic        in_valid;
    logic [31:0] product;
    logic        out_ready;

    logic        in_ready, out_valid, busy, ovf;
    logic [39:0] acc_out;
    logic        in_ready33, out_valid33, busy33, ovf33;
    logic [32:0] acc_out33;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mac_acc_tc #(.ACC_W(40)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .in_valid(in_valid), .in_ready(in_ready), .product(product),
        .out_valid(out_valid), .out_ready(out_ready), .acc_out(acc_out),
        .busy(busy), .ovf(ovf)
    );

    mac_acc_tc #(.ACC_W(33)) dut33 (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .in_valid(in_valid), .in_ready(in_ready33), .product(product),
        .out_valid(out_valid33), .out_ready(out_ready), .acc_out(acc_out33),
        .busy(busy33), .ovf(ovf33)
    );

    typedef struct {
        int          len;
        logic [31:0] p [4];
        int          gap;
        int          rdy_hold;
        logic [39:0] exp40;
    } vec_t;

    typedef struct {
        logic [63:0] a40;
        logic        o40;
        logic [63:0] a33;
        logic        o33;
    } sb_t;

    vec_t vecs [8];
    sb_t  sb_q [$];

    logic [63:0] m40, m33;
    logic        mo40, mo33;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model of one accumulate step at width w: returns {overflow, new value}.
    function automatic logic [64:0] madd(input logic [63:0] acc, input logic [31:0] p, input int w);
        logic [63:0] mask, pe, s, minn, maxp;
        logic        sa, sp, ss, o;
        mask = (64'd1 << w) - 64'd1;
        pe   = {{32{p[31]}}, p};
        s    = (acc + pe) & mask;
        sa   = acc[w-1];
        sp   = p[31];
        ss   = s[w-1];
        o    = (sa == sp) && (ss != sa);
        minn = 64'd1 << (w - 1);
        maxp = minn - 64'd1;
`ifdef MAC_ACC_SAT_EN
        if (o) s = sp ? minn : maxp;
`else
        if (o && (maxp == minn)) s = maxp;
`endif
        return {o, s};
    endfunction

    task automatic model_clear();
        m40 = '0; m33 = '0; mo40 = 1'b0; mo33 = 1'b0;
    endtask

    task automatic model_beat(input logic [31:0] p);
        logic [64:0] r;
        r = madd(m40, p, 40); m40 = r[63:0]; mo40 = mo40 | r[64];
        r = madd(m33, p, 33); m33 = r[63:0]; mo33 = mo33 | r[64];
    endtask

    task automatic model_push();
        sb_t e;
        e.a40 = m40; e.o40 = mo40; e.a33 = m33; e.o33 = mo33;
        sb_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_vec(input int i, input int l, input logic [31:0] p0, input logic [31:0] p1,
                           input logic [31:0] p2, input logic [31:0] p3, input int g, input int rh,
                           input logic [39:0] e);
        vecs[i].len = l;
        vecs[i].p[0] = p0; vecs[i].p[1] = p1; vecs[i].p[2] = p2; vecs[i].p[3] = p3;
        vecs[i].gap = g; vecs[i].rdy_hold = rh; vecs[i].exp40 = e;
    endtask

    // Result monitor: every accepted result must match the oldest expected entry.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_out_valid", 64'd1, 64'd0);
            end else begin
                sb_t e;
                e = sb_q.pop_front();
                check("sb_acc40", 64'(acc_out), e.a40);
                check("sb_ovf40", 64'(ovf), 64'(e.o40));
                check("sb_acc33", 64'(acc_out33), e.a33);
                check("sb_ovf33", 64'(ovf33), 64'(e.o33));
                check("sb_lockstep33", 64'(out_valid33), 64'd1);
            end
        end
    end

    task automatic run_vec(input int idx);
        vec_t v;
        v = vecs[idx];
        check($sformatf("v%0d_idle_busy", idx), 64'(busy), 64'd0);
        start = 1'b1; len = 8'(v.len);
        tick();
        start = 1'b0;
        model_clear();
        for (int i = 0; i < v.len; i++) begin
            for (int g = 0; g < v.gap; g++) begin
                in_valid = 1'b0;
                tick();
                check($sformatf("v%0d_gap_hold", idx), 64'(acc_out), m40);
            end
            in_valid = 1'b1; product = v.p[i];
            check($sformatf("v%0d_in_ready", idx), 64'(in_ready), 64'd1);
            tick();
            in_valid = 1'b0;
            model_beat(v.p[i]);
        end
        model_push();
        check($sformatf("v%0d_out_valid_latency", idx), 64'(out_valid), 64'd1);
        check($sformatf("v%0d_in_ready_done", idx), 64'(in_ready), 64'd0);
        check($sformatf("v%0d_acc_const", idx), 64'(acc_out), 64'(v.exp40));
        if (idx == 5) begin
`ifdef MAC_ACC_SAT_EN
            check("w33_sat_acc", 64'(acc_out33), 64'h0_FFFF_FFFF);
`else
            check("w33_wrap_acc", 64'(acc_out33), 64'h1_7FFF_FFFD);
`endif
            check("w33_ovf", 64'(ovf33), 64'd1);
        end
        for (int h = 0; h < v.rdy_hold; h++) begin
            out_ready = 1'b0;
            tick();
            check($sformatf("v%0d_hold_valid", idx), 64'(out_valid), 64'd1);
            check($sformatf("v%0d_hold_acc", idx), 64'(acc_out), 64'(v.exp40));
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check($sformatf("v%0d_back_idle_valid", idx), 64'(out_valid), 64'd0);
        check($sformatf("v%0d_back_idle_busy", idx), 64'(busy), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        set_vec(0, 3, 32'd5, 32'hFFFF_FFFE, 32'd100, 32'd0, 0, 0, 40'd103);
        set_vec(1, 0, 32'd0, 32'd0, 32'd0, 32'd0, 0, 0, 40'd0);
        set_vec(2, 2, 32'h7FFF_FFFF, 32'h0000_0001, 32'd0, 32'd0, 3, 4, 40'h00_8000_0000);
        set_vec(3, 4, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1, 40'hFF_FFFF_FFFC);
        set_vec(4, 1, 32'h8000_0000, 32'd0, 32'd0, 32'd0, 0, 0, 40'hFF_8000_0000);
        set_vec(5, 3, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'd0, 0, 0, 40'h01_7FFF_FFFD);
        set_vec(6, 4, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 1, 2, 40'hFE_0000_0000);
        set_vec(7, 1, 32'hFFFF_FFF9, 32'd0, 32'd0, 32'd0, 0, 0, 40'hFF_FFFF_FFF9);

        rst = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0; product = '0; out_ready = 1'b0;
        repeat (3) tick();
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_acc", 64'(acc_out), 64'd0);
        check("rst_ovf", 64'(ovf), 64'd0);
        check("rst_acc33", 64'(acc_out33), 64'd0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 8; i++) run_vec(i);

        // Start during ACC and DONE, and together with the DONE handshake, is ignored.
        start = 1'b1; len = 8'd2;
        tick();
        start = 1'b0;
        model_clear();
        in_valid = 1'b1; product = 32'd10;
        tick();
        in_valid = 1'b0; model_beat(32'd10);
        start = 1'b1; len = 8'd5;
        tick();
        start = 1'b0;
        check("ign_acc_sum", 64'(acc_out), 64'd10);
        check("ign_acc_ready", 64'(in_ready), 64'd1);
        in_valid = 1'b1; product = 32'd20;
        tick();
        in_valid = 1'b0; model_beat(32'd20); model_push();
        check("ign_done_reached", 64'(out_valid), 64'd1);
        start = 1'b1; len = 8'd9;
        tick();
        check("ign_done_valid", 64'(out_valid), 64'd1);
        check("ign_done_acc", 64'(acc_out), 64'd30);
        out_ready = 1'b1;
        tick();
        start = 1'b0; out_ready = 1'b0;
        check("ign_hs_start_busy", 64'(busy), 64'd0);
        tick();
        check("ign_hs_start_idle", 64'(busy), 64'd0);

        // Reset mid-run with start/in_valid asserted: run aborted, no stale result.
        out_ready = 1'b1;
        start = 1'b1; len = 8'd4;
        tick();
        start = 1'b0;
        in_valid = 1'b1; product = 32'd3;
        tick();
        rst = 1'b1; start = 1'b1; in_valid = 1'b1; product = 32'd5;
        tick();
        rst = 1'b0; start = 1'b0; in_valid = 1'b0;
        check("rmid_busy", 64'(busy), 64'd0);
        check("rmid_in_ready", 64'(in_ready), 64'd0);
        check("rmid_acc", 64'(acc_out), 64'd0);
        check("rmid_ovf", 64'(ovf), 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rmid_no_stale_valid", 64'(out_valid), 64'd0);
        end
        out_ready = 1'b0;
        run_vec(7);

        // Reset while a result waits in DONE discards it.
        start = 1'b1; len = 8'd0;
        tick();
        start = 1'b0;
        check("rdone_valid", 64'(out_valid), 64'd1);
        rst = 1'b1; out_ready = 1'b1;
        tick();
        rst = 1'b0;
        check("rdone_dropped", 64'(out_valid), 64'd0);
        tick();
        out_ready = 1'b0;
        check("rdone_still_idle", 64'(busy), 64'd0);

        repeat (2) tick();
        check("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
